period_meter: RTL and testbench

Measures the period of an incoming slow square wave, such as a divided clock or a generated output looped back, in cycles of the system clock. It is the receive-side counterpart of the clock-divider blocks. It synchronises the asynchronous input, detects rising edges, and counts `CLOCK` cycles between successive edges. It then publishes the result with a one-cycle valid strobe for display and self-check logic.

---
 rtl/period_meter_pkg.sv | 12 +
 rtl/sync_edge_detect.sv | 33 +++
 rtl/period_meter.sv | 130 +++++++++++++
 tb/tb_period_meter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period_meter block.
package period_meter_pkg;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } state_e;

    localparam int unsigned DEF_CNT_W       = 26;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level with rise/fall detection
// against a history flop; reusable by any async-input block (STAGES >= 2).
module sync_edge_detect
    import period_meter_pkg::*;
#(
    parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic ASYNC_IN,
    output logic LEVEL,
    output logic RISE,
    output logic FALL
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], ASYNC_IN};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign LEVEL = sync_q[STAGES-1];
    assign RISE  = sync_q[STAGES-1] & ~hist_q;
    assign FALL  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/period_meter.sv
// Measures the period of a slow async square wave in CLOCK cycles, strobing each result.
// Optional HIGH_TIME output is built when PERIOD_METER_HIGHTIME_EN is defined.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             SIG_IN,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VALID,
    output logic             OVERFLOW
`ifdef PERIOD_METER_HIGHTIME_EN
    ,
    output logic [CNT_W-1:0] HIGH_TIME
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic sig_level;
    logic rise;
    logic fall;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .ASYNC_IN (SIG_IN),
        .LEVEL    (sig_level),
        .RISE     (rise),
        .FALL     (fall)
    );

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sat_q;
    logic             sat_d;

    // Saturating increment: the count pins at all-ones and flags the interval as overflowed.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        sat_d = sat_q | (cnt_d == CNT_MAX);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= WAIT_FIRST;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            PERIOD       <= '0;
            PERIOD_VALID <= 1'b0;
            OVERFLOW     <= 1'b0;
        end else begin
            PERIOD_VALID <= 1'b0;
            if (!ENABLE) begin
                state_q <= WAIT_FIRST;
                cnt_q   <= '0;
                sat_q   <= 1'b0;
            end else begin
                case (state_q)
                    WAIT_FIRST: begin
                        if (rise) begin
                            state_q <= MEASURE;
                            cnt_q   <= CNT_ONE;
                            sat_q   <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            PERIOD       <= cnt_q;
                            OVERFLOW     <= sat_q;
                            PERIOD_VALID <= 1'b1;
                            cnt_q        <= CNT_ONE;
                            sat_q        <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                            sat_q <= sat_d;
                        end
                    end
                    default: begin
                        state_q <= WAIT_FIRST;
                    end
                endcase
            end
        end
    end

`ifdef PERIOD_METER_HIGHTIME_EN
    logic [CNT_W-1:0] hi_shadow_q;
    logic             fall_seen_q;
    logic             unused_sync;

    assign unused_sync = sig_level;

    // The period counter restarts at each rise, so its value at the fall is already the
    // (saturated) high time; it serves as the high-time counter.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            HIGH_TIME   <= '0;
            hi_shadow_q <= '0;
            fall_seen_q <= 1'b0;
        end else if (!ENABLE) begin
            fall_seen_q <= 1'b0;
        end else if (state_q == MEASURE) begin
            if (rise) begin
                HIGH_TIME   <= fall_seen_q ? hi_shadow_q : cnt_q;
                fall_seen_q <= 1'b0;
            end else if (fall) begin
                hi_shadow_q <= cnt_q;
                fall_seen_q <= 1'b1;
            end
        end
    end
`else
    logic unused_sync;

    assign unused_sync = ^{sig_level, fall};
`endif

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: three instances (default, CNT_W=8, SYNC_STAGES=3)
// share one stimulus; each scenario task checks strobed values against hand-computed lists.
module tb_period_meter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        sig;

    logic [25:0] p_m;
    logic        v_m;
    logic        o_m;
    logic [7:0]  p_8;
    logic        v_8;
    logic        o_8;
    logic [25:0] p_3;
    logic        v_3;
    logic        o_3;
`ifdef PERIOD_METER_HIGHTIME_EN
    logic [25:0] h_m;
    logic [7:0]  h_8;
    logic [25:0] h_3;
`endif

    int n_chk;
    int n_fail;

    int seg_hi[$];
    int seg_lo[$];
    int ex_p[$];
    int ex_p8[$];
    bit ex_o8[$];
    int ex_h[$];

    localparam int TAIL = 8;

    period_meter dut_m (
        .CLOCK        (clk),
        .RESET        (rst),
        .ENABLE       (en),
        .SIG_IN       (sig),
        .PERIOD       (p_m),
        .PERIOD_VALID (v_m),
        .OVERFLOW     (o_m)
`ifdef PERIOD_METER_HIGHTIME_EN
        ,
        .HIGH_TIME    (h_m)
`endif
    );

    period_meter #(
        .CNT_W (8)
    ) dut_8 (
        .CLOCK        (clk),
        .RESET        (rst),
        .ENABLE       (en),
        .SIG_IN       (sig),
        .PERIOD       (p_8),
        .PERIOD_VALID (v_8),
        .OVERFLOW     (o_8)
`ifdef PERIOD_METER_HIGHTIME_EN
        ,
        .HIGH_TIME    (h_8)
`endif
    );

    period_meter #(
        .SYNC_STAGES (3)
    ) dut_3 (
        .CLOCK        (clk),
        .RESET        (rst),
        .ENABLE       (en),
        .SIG_IN       (sig),
        .PERIOD       (p_3),
        .PERIOD_VALID (v_3),
        .OVERFLOW     (o_3)
`ifdef PERIOD_METER_HIGHTIME_EN
        ,
        .HIGH_TIME    (h_3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_seg(input int h, input int l);
        seg_hi.push_back(h);
        seg_lo.push_back(l);
    endtask

    task automatic add_exp(input int p, input int p8, input bit o8, input int h);
        ex_p.push_back(p);
        ex_p8.push_back(p8);
        ex_o8.push_back(o8);
        ex_h.push_back(h);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        sig = 1'b0;
        en  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Plays the queued segments (each: rise, hi cycles high, lo cycles low) plus a low tail.
    // Each iteration samples outputs at the negedge and then drives SIG_IN for that cycle.
    task automatic run_segs(input string name, input int first_m, input int first_3);
        int k_m;
        int k_8;
        int k_3;
        int idx;
        int fm;
        int f3;
        int nseg;
        int len;
        k_m = 0; k_8 = 0; k_3 = 0; idx = 0; fm = -1; f3 = -1;
        nseg = seg_hi.size();
        for (int s = 0; s <= nseg; s++) begin
            len = (s < nseg) ? seg_hi[s] + seg_lo[s] : TAIL;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if (v_m) begin
                    if (fm < 0) fm = idx;
                    n_chk++;
                    if (k_m >= ex_p.size()) begin
                        n_fail++;
                        $display("FAIL %s main extra strobe: PERIOD=%0d at cycle %0d, required no strobe", name, p_m, idx);
                    end else begin
                        if (p_m !== 26'(ex_p[k_m])) begin
                            n_fail++;
                            $display("FAIL %s main PERIOD[%0d]: got %0d, required %0d", name, k_m, p_m, ex_p[k_m]);
                        end
                        n_chk++;
                        if (o_m !== 1'b0) begin
                            n_fail++;
                            $display("FAIL %s main OVERFLOW[%0d]: got %b, required 0", name, k_m, o_m);
                        end
`ifdef PERIOD_METER_HIGHTIME_EN
                        n_chk++;
                        if (h_m !== 26'(ex_h[k_m])) begin
                            n_fail++;
                            $display("FAIL %s main HIGH_TIME[%0d]: got %0d, required %0d", name, k_m, h_m, ex_h[k_m]);
                        end
`endif
                    end
                    k_m++;
                end
                if (v_8) begin
                    n_chk++;
                    if (k_8 >= ex_p8.size()) begin
                        n_fail++;
                        $display("FAIL %s w8 extra strobe: PERIOD=%0d at cycle %0d, required no strobe", name, p_8, idx);
                    end else begin
                        if (p_8 !== 8'(ex_p8[k_8])) begin
                            n_fail++;
                            $display("FAIL %s w8 PERIOD[%0d]: got %0d, required %0d", name, k_8, p_8, ex_p8[k_8]);
                        end
                        n_chk++;
                        if (o_8 !== ex_o8[k_8]) begin
                            n_fail++;
                            $display("FAIL %s w8 OVERFLOW[%0d]: got %b, required %b", name, k_8, o_8, ex_o8[k_8]);
                        end
                    end
                    k_8++;
                end
                if (v_3) begin
                    if (f3 < 0) f3 = idx;
                    n_chk++;
                    if (k_3 >= ex_p.size()) begin
                        n_fail++;
                        $display("FAIL %s sync3 extra strobe: PERIOD=%0d at cycle %0d, required no strobe", name, p_3, idx);
                    end else if (p_3 !== 26'(ex_p[k_3]) || o_3 !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s sync3 PERIOD/OVERFLOW[%0d]: got %0d/%b, required %0d/0", name, k_3, p_3, o_3, ex_p[k_3]);
                    end
                    k_3++;
                end
                sig = (s < nseg) && (c < seg_hi[s]);
                idx++;
            end
        end
        n_chk++;
        if (k_m != ex_p.size()) begin
            n_fail++;
            $display("FAIL %s main strobe count: got %0d, required %0d", name, k_m, ex_p.size());
        end
        n_chk++;
        if (k_8 != ex_p8.size()) begin
            n_fail++;
            $display("FAIL %s w8 strobe count: got %0d, required %0d", name, k_8, ex_p8.size());
        end
        n_chk++;
        if (k_3 != ex_p.size()) begin
            n_fail++;
            $display("FAIL %s sync3 strobe count: got %0d, required %0d", name, k_3, ex_p.size());
        end
        n_chk++;
        if (fm != first_m) begin
            n_fail++;
            $display("FAIL %s main first strobe cycle: got %0d, required %0d", name, fm, first_m);
        end
        n_chk++;
        if (f3 != first_3) begin
            n_fail++;
            $display("FAIL %s sync3 first strobe cycle: got %0d, required %0d", name, f3, first_3);
        end
        seg_hi.delete(); seg_lo.delete();
        ex_p.delete(); ex_p8.delete(); ex_o8.delete(); ex_h.delete();
    endtask

    task automatic check_all_zero(input string name);
        n_chk++;
        if (p_m !== '0 || v_m !== 1'b0 || o_m !== 1'b0) begin
            n_fail++;
            $display("FAIL %s main outputs: got P=%0d V=%b O=%b, required 0/0/0", name, p_m, v_m, o_m);
        end
        n_chk++;
        if (p_8 !== '0 || v_8 !== 1'b0 || o_8 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s w8 outputs: got P=%0d V=%b O=%b, required 0/0/0", name, p_8, v_8, o_8);
        end
        n_chk++;
        if (p_3 !== '0 || v_3 !== 1'b0 || o_3 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s sync3 outputs: got P=%0d V=%b O=%b, required 0/0/0", name, p_3, v_3, o_3);
        end
`ifdef PERIOD_METER_HIGHTIME_EN
        n_chk++;
        if (h_m !== '0 || h_8 !== '0 || h_3 !== '0) begin
            n_fail++;
            $display("FAIL %s HIGH_TIME: got %0d/%0d/%0d, required 0", name, h_m, h_8, h_3);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b1;
        sig = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_square16();
        reset_dut();
        for (int i = 0; i < 6; i++) add_seg(8, 8);
        for (int i = 0; i < 5; i++) add_exp(16, 16, 1'b0, 8);
        run_segs("square16", 19, 20);
    endtask

    task automatic test_period_change();
        reset_dut();
        add_seg(8, 8); add_seg(8, 8); add_seg(8, 3);
        add_seg(3, 3); add_seg(3, 3); add_seg(3, 3);
        add_exp(16, 16, 1'b0, 8);
        add_exp(16, 16, 1'b0, 8);
        add_exp(11, 11, 1'b0, 8);
        add_exp(6, 6, 1'b0, 3);
        add_exp(6, 6, 1'b0, 3);
        run_segs("period_change", 19, 20);
    endtask

    task automatic test_overflow();
        reset_dut();
        add_seg(4, 300); add_seg(4, 12); add_seg(4, 12);
        add_exp(304, 255, 1'b1, 4);
        add_exp(16, 16, 1'b0, 4);
        run_segs("overflow", 307, 308);
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int i = 0; i < 3; i++) add_seg(8, 8);
        add_exp(16, 16, 1'b0, 8);
        add_exp(16, 16, 1'b0, 8);
        run_segs("pre_reset", 19, 20);
        @(negedge clk);
        n_chk++;
        if (p_m !== 26'd16) begin
            n_fail++;
            $display("FAIL reset_mid PERIOD before reset: got %0d, required 16", p_m);
        end
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) add_seg(8, 8);
        add_exp(16, 16, 1'b0, 8);
        add_exp(16, 16, 1'b0, 8);
        run_segs("post_reset", 19, 20);
    endtask

    task automatic test_enable();
        reset_dut();
        for (int i = 0; i < 3; i++) add_seg(8, 8);
        add_exp(16, 16, 1'b0, 8);
        add_exp(16, 16, 1'b0, 8);
        run_segs("pre_disable", 19, 20);
        en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_chk++;
            if (v_m !== 1'b0 || v_8 !== 1'b0 || v_3 !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled strobe at cycle %0d: got %b%b%b, required 000", c, v_m, v_8, v_3);
            end
            n_chk++;
            if (p_m !== 26'd16 || o_m !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled hold at cycle %0d: got P=%0d O=%b, required 16/0", c, p_m, o_m);
            end
            sig = ((c % 10) < 5);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) add_seg(6, 6);
        add_exp(12, 12, 1'b0, 6);
        add_exp(12, 12, 1'b0, 6);
        run_segs("re_enable", 15, 16);
    endtask

    task automatic test_sync3();
        reset_dut();
        for (int i = 0; i < 6; i++) add_seg(2, 2);
        for (int i = 0; i < 5; i++) add_exp(4, 4, 1'b0, 2);
        run_segs("fast4_sync3", 7, 8);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_square16();
        test_period_change();
        test_overflow();
        test_reset_mid();
        test_enable();
        test_sync3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
